icache_dm_param: RTL and testbench

Parametrised direct-mapped instruction cache between the fetch stage and the memory arbiter.
- Successor to the fixed 8-line × 16-word I-cache: configurable line count and line size.
- Adds per-line valid bits, a flush input, a registered fetch handshake and a fully synchronous refill FSM driven by a word-level memory handshake.
- Serves one fetch at a time; a miss refills the whole line, then returns the requested word.

---
 rtl/icache_dm_param.sv | 165 ++++++++++++++++
 tb/tb_icache_dm_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache_dm_param.sv
// Direct-mapped I-cache with configurable geometry. `ICACHE_STATS_EN adds hit/miss counters.
// Latency: hit 1 cycle; miss LINE_WORDS memory acks + 1 cycle.
// Backpressure: rdy=0 freezes all state; fetch_idle=0 while busy; refill paced by mem_ack.
module icache_dm_param #(
  parameter int NUM_LINES  = 8,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_idle,
  output logic              fetch_valid,
  output logic [31:0]       fetch_inst,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - 2 - OW - IW;
  localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t          state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]   tag_mem  [NUM_LINES];
  logic [31:0]     data_mem [NUM_LINES][LINE_WORDS];
  logic [TW-1:0]   lat_tag;
  logic [IW-1:0]   lat_idx;
  logic [OW-1:0]   lat_off;
  logic [OW-1:0]   cnt_q;
  logic            flushed_q;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic [OW-1:0]   req_off;
  logic            hit;
  logic            unused_addr_lsb;

  assign req_off = fetch_addr[2 +: OW];
  assign req_idx = fetch_addr[2+OW +: IW];
  assign req_tag = fetch_addr[ADDR_W-1 -: TW];
  assign unused_addr_lsb = ^fetch_addr[1:0];

  // A flush in the same cycle turns a would-be hit into a miss.
  assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else if (rdy)
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fetch_idle = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_idle = 1'b1;
        if (fetch_req && !hit)
          state_d = REFILL;
      end
      REFILL: begin
        if (mem_ack && cnt_q == LAST_WORD)
          state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
      lat_tag     <= '0;
      lat_idx     <= '0;
      lat_off     <= '0;
      fetch_valid <= 1'b0;
      fetch_inst  <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy) begin
      fetch_valid <= 1'b0;
      if (flush)
        valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            lat_tag <= req_tag;
            lat_idx <= req_idx;
            lat_off <= req_off;
            if (hit) begin
              fetch_valid <= 1'b1;
              fetch_inst  <= data_mem[req_idx][req_off];
            end else begin
              cnt_q            <= '0;
              flushed_q        <= 1'b0;
              mem_req          <= 1'b1;
              mem_addr         <= {req_tag, req_idx, {OW{1'b0}}, 2'b00};
              valid_q[req_idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (flush)
            flushed_q <= 1'b1;
          if (mem_ack) begin
            cnt_q <= cnt_q + OW'(1);
            if (cnt_q == LAST_WORD) begin
              mem_req          <= 1'b0;
              valid_q[lat_idx] <= !(flushed_q || flush);
            end else begin
              mem_addr <= mem_addr + ADDR_W'(4);
            end
          end
        end
        RESPOND: begin
          fetch_valid <= 1'b1;
          fetch_inst  <= data_mem[lat_idx][lat_off];
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      if (state_q == IDLE && fetch_req && !hit)
        tag_mem[req_idx] <= req_tag;
      if (state_q == REFILL && mem_ack)
        data_mem[lat_idx][cnt_q] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy && state_q == IDLE && fetch_req) begin
      if (hit)
        hit_count <= hit_count + 32'd1;
      else
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// Directed bench for icache_dm_param (default 8 lines x 16 words, 32-bit addresses).
module tb_icache_dm_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_idle;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int n_vec = 0;
  int n_err = 0;

  icache_dm_param dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_idle (fetch_idle),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
  endtask

  // Serves a whole line refill starting one edge after the miss was accepted,
  // then checks the response cycle and the return to idle.
  task automatic refill(input logic [31:0] base, input logic [31:0] dbase,
                        input logic [31:0] exp_inst, input int flush_k, input int stall_k);
    for (int k = 0; k < 16; k++) begin
      chk("refill_req", 32'(mem_req), 32'd1);
      chk("refill_addr", mem_addr, base + 32'(4 * k));
      if (k == stall_k) begin
        for (int s = 0; s < 3; s++) begin
          rdy      = 1'b0;
          mem_ack  = 1'b1;
          mem_data = 32'hDEAD_BEEF;
          tick();
          chk("stall_addr", mem_addr, base + 32'(4 * k));
          chk("stall_req", 32'(mem_req), 32'd1);
        end
        rdy = 1'b1;
      end
      flush    = (k == flush_k);
      mem_ack  = 1'b1;
      mem_data = dbase + 32'(k);
      tick();
    end
    mem_ack  = 1'b0;
    mem_data = '0;
    flush    = 1'b0;
    chk("respond_req", 32'(mem_req), 32'd0);
    chk("respond_valid", 32'(fetch_valid), 32'd0);
    chk("respond_idle", 32'(fetch_idle), 32'd0);
    tick();
    chk("miss_valid", 32'(fetch_valid), 32'd1);
    chk("miss_inst", fetch_inst, exp_inst);
    chk("miss_idle", 32'(fetch_idle), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_data   = '0;
    tick();
    chk("rst_idle", 32'(fetch_idle), 32'd1);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_inst", fetch_inst, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Cold miss on line 1, tag 0.
    issue(32'h40);
    chk("cold_req", 32'(mem_req), 32'd1);
    chk("cold_idle", 32'(fetch_idle), 32'd0);
    refill(32'h40, 32'h1000, 32'h1000, -1, -1);
    tick();
    chk("pulse_once", 32'(fetch_valid), 32'd0);

    // Hit one cycle after the request.
    issue(32'h44);
    chk("hit_valid", 32'(fetch_valid), 32'd1);
    chk("hit_inst", fetch_inst, 32'h1001);
    chk("hit_memreq", 32'(mem_req), 32'd0);
    chk("hit_idle", 32'(fetch_idle), 32'd1);
    tick();
    chk("hit_pulse", 32'(fetch_valid), 32'd0);

    // Same index, tag 1; 0x240 is already line-aligned.
    issue(32'h240);
    chk("alias_req", 32'(mem_req), 32'd1);
    refill(32'h240, 32'h2000, 32'h2000, -1, -1);
    issue(32'h44);
    chk("alias_back_valid", 32'(fetch_valid), 32'd0);
    chk("alias_back_req", 32'(mem_req), 32'd1);
    refill(32'h40, 32'h3000, 32'h3001, -1, -1);

    // Flush during the fifth refill cycle leaves the line invalid.
    issue(32'h88);
    refill(32'h80, 32'h4000, 32'h4002, 4, -1);
    issue(32'h88);
    chk("flush_refetch_valid", 32'(fetch_valid), 32'd0);
    chk("flush_refetch_req", 32'(mem_req), 32'd1);
    refill(32'h80, 32'h5000, 32'h5002, -1, -1);

    // rdy stall with acks pulsed while frozen.
    issue(32'hCC);
    refill(32'hC0, 32'h6000, 32'h6003, -1, 5);
    issue(32'hD4);
    chk("stall_hit_valid", 32'(fetch_valid), 32'd1);
    chk("stall_hit_inst", fetch_inst, 32'h6005);

    // Flush with a request in the same idle cycle forces a miss.
    flush = 1'b1;
    issue(32'hC4);
    flush = 1'b0;
    chk("idle_flush_valid", 32'(fetch_valid), 32'd0);
    chk("idle_flush_req", 32'(mem_req), 32'd1);
    refill(32'hC0, 32'h8000, 32'h8001, -1, -1);

    // Reset in the middle of a refill.
    issue(32'h100);
    for (int k = 0; k < 3; k++) begin
      mem_ack  = 1'b1;
      mem_data = 32'h7000 + 32'(k);
      tick();
    end
    mem_ack = 1'b0;
    rst     = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_idle", 32'(fetch_idle), 32'd1);
    chk("arst_valid", 32'(fetch_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    issue(32'h100);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_valid", 32'(fetch_valid), 32'd0);
    refill(32'h100, 32'h9000, 32'h9000, -1, -1);
    issue(32'h104);
    chk("post_rst_hit", fetch_inst, 32'h9001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
